// File: rtl/prdd_coder.sv
`default_nettype none
// ============================================================================
// Module   : prdd_coder
// Purpose  : Registered N-to-M priority encoder. Reports the index of the
//            highest-priority asserted bit of a request vector together with
//            a valid flag, one clock after the vector is presented.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N          request vector width (N >= 2)
//   M          index width, must satisfy 2**M >= N
//   MSB_FIRST  1: highest set bit wins, 0: lowest set bit wins
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   in     in   N   request vector, any number of bits may be set
//   out    out  M   index of the winning bit (0 when nothing is set)
//   valid  out  1   1 when any request bit was set
// ============================================================================
module prdd_coder #(
  parameter int N         = 16,
  parameter int M         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic [M-1:0] out,
  output logic         valid
);

  // Parameter legality: the index must be able to name every request bit.
  generate
    if (N < 2) begin : g_bad_width
      $error("prdd_coder: N must be at least 2 (N=%0d)", N);
    end
    if ((2 ** M) < N) begin : g_bad_index
      $error("prdd_coder: 2**M must be >= N (N=%0d, M=%0d)", N, M);
    end
  endgenerate

  logic [M-1:0] w_idx;
  logic         w_any;
  logic [M-1:0] r_out;
  logic         r_valid;

  // Priority scan. The loop direction is chosen so the winning bit is the
  // last one to write w_idx: ascending for MSB-first, descending for
  // LSB-first. w_idx stays 0 when no bit is set, which is also the required
  // "none" output value.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
          if (in[i]) begin
            w_idx = M'(i);
          end
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (in[i]) begin
            w_idx = M'(i);
          end
        end
      end
    end
  endgenerate

  assign w_any = |in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_any ? w_idx : '0;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_prdd_coder.sv
`default_nettype none
// ============================================================================
// Module   : tb_prdd_coder
// Purpose  : Scoreboard bench for prdd_coder. One MSB-first and one LSB-first
//            instance share the same request vector; expectations come from
//            an arithmetic reference model and are queued at stimulus time,
//            then popped and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prdd_coder;

  localparam int N = 16;
  localparam int M = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in;
  logic [M-1:0] out_m;
  logic         valid_m;
  logic [M-1:0] out_l;
  logic         valid_l;

  int checks;
  int failures;

  typedef struct {
    logic [N-1:0] vec;
    logic [M-1:0] exp_m;
    logic [M-1:0] exp_l;
    logic         exp_v;
  } exp_t;

  exp_t sb[$];

  prdd_coder #(.N(N), .M(M), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out_m),
    .valid (valid_m)
  );

  prdd_coder #(.N(N), .M(M), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out_l),
    .valid (valid_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: highest set bit is floor(log2 v) = clog2(v+1)-1; lowest set
  // bit is found by isolating it with v & -v and taking its log2.
  function automatic logic [M-1:0] ref_msb(input logic [N-1:0] v);
    int x;
    x = int'(v);
    if (x == 0) return '0;
    return M'($clog2(x + 1) - 1);
  endfunction

  function automatic logic [M-1:0] ref_lsb(input logic [N-1:0] v);
    int x;
    x = int'(v);
    if (x == 0) return '0;
    return M'($clog2(x & -x));
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Present a vector on the falling edge and queue what the next rising
  // edge must produce.
  task automatic drive(input logic [N-1:0] v);
    exp_t e;
    @(negedge clk);
    in      = v;
    e.vec   = v;
    e.exp_m = ref_msb(v);
    e.exp_l = ref_lsb(v);
    e.exp_v = (v != '0);
    sb.push_back(e);
  endtask

  // Monitor: every capturing edge with a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        #1;
        check($sformatf("msb_out in=%h", e.vec), int'(out_m), int'(e.exp_m));
        check($sformatf("msb_valid in=%h", e.vec), int'(valid_m), int'(e.exp_v));
        check($sformatf("lsb_out in=%h", e.vec), int'(out_l), int'(e.exp_l));
        check($sformatf("lsb_valid in=%h", e.vec), int'(valid_l), int'(e.exp_v));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in       = 16'hFFFF;

    // Reset held with all bits requested: outputs stay cleared.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_msb", int'(out_m), 0);
    check("reset_valid_msb", int'(valid_m), 0);
    check("reset_out_lsb", int'(out_l), 0);
    check("reset_valid_lsb", int'(valid_l), 0);

    // Release; the first edge captures 16'hFFFF (out=15 / out=0, valid=1).
    rst_n = 1'b1;
    begin
      exp_t e;
      e.vec   = 16'hFFFF;
      e.exp_m = 4'd15;
      e.exp_l = 4'd0;
      e.exp_v = 1'b1;
      sb.push_back(e);
    end

    drive(16'h0000);

    // One-hot sweep from bit 15 down to bit 0.
    for (int i = N - 1; i >= 0; i--) begin
      drive(N'(1) << i);
    end

    // Multiple-bit priority cases.
    drive(16'b0010_0000_1000_0001);
    drive(16'h0003);
    drive(16'h0300);
    drive(16'hFFFF);
    drive(16'h8001);

    // Random vectors, biased so sparse and empty vectors also appear.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & N'($urandom);
        1: v = v & N'($urandom) & N'($urandom);
        2: if ($urandom_range(0, 7) == 0) v = '0;
        default: ;
      endcase
      drive(v);
    end

    // Asynchronous reset between edges, then recovery on the next edge.
    drive(16'h0400);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_msb", int'(out_m), 0);
    check("async_rst_valid_msb", int'(valid_m), 0);
    check("async_rst_out_lsb", int'(out_l), 0);
    check("async_rst_valid_lsb", int'(valid_l), 0);
    rst_n = 1'b1;
    drive(16'h0400);

    // Bit 0 set versus nothing set.
    drive(16'h0001);
    drive(16'h0000);

    @(negedge clk);
    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
